// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} kp_state_t;
  typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} kp_frame_t;

  function automatic logic [3:0] kp_encode(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level press/release debouncer: accepts a key after DEBOUNCE identical single-key
// frames, releases after DEBOUNCE key-free frames; outputs registered, strobe lasts one cycle.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_done_i,
  input  kp_frame_t  frame_type_i,
  input  logic [3:0] frame_code_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_strobe_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  // cnt value at which one more matching frame completes the run
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  kp_state_t  state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] cand_q;
  logic [3:0] key_code_q;
  logic       key_valid_q;
  logic       key_strobe_q;
  logic       run_done;

  assign run_done = (cnt_q >= LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cand_q       <= '0;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      key_strobe_q <= 1'b0;
    end else begin
      key_strobe_q <= 1'b0;
      if (frame_done_i) begin
        unique case (state_q)
          IDLE: begin
            if (frame_type_i == F_SINGLE) begin
              cand_q <= frame_code_i;
              cnt_q  <= CW'(1);
              if (DEBOUNCE == 1) begin
                key_code_q   <= frame_code_i;
                key_valid_q  <= 1'b1;
                key_strobe_q <= 1'b1;
                state_q      <= HELD;
              end else begin
                state_q <= PRESS_CHK;
              end
            end
          end
          PRESS_CHK: begin
            if (frame_type_i == F_SINGLE && frame_code_i == cand_q) begin
              if (run_done) begin
                cnt_q        <= CW'(DEBOUNCE);
                key_code_q   <= cand_q;
                key_valid_q  <= 1'b1;
                key_strobe_q <= 1'b1;
                state_q      <= HELD;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else if (frame_type_i == F_SINGLE) begin
              cand_q <= frame_code_i;
              cnt_q  <= CW'(1);
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
          HELD: begin
            // No rollover: only a key-free frame can start a release
            if (frame_type_i == F_NONE) begin
              cnt_q <= CW'(1);
              if (DEBOUNCE == 1) begin
                key_valid_q <= 1'b0;
                cnt_q       <= '0;
                state_q     <= IDLE;
              end else begin
                state_q <= RELEASE_CHK;
              end
            end
          end
          RELEASE_CHK: begin
            if (frame_type_i == F_NONE) begin
              if (run_done) begin
                cnt_q       <= '0;
                key_valid_q <= 1'b0;
                state_q     <= IDLE;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_code_o   = key_code_q;
  assign key_valid_o  = key_valid_q;
  assign key_strobe_o = key_strobe_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad front end: walks the active-low rows, samples columns at the end of each row slot,
// merges the four slots into one frame verdict and hands it to the debouncer.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 250000,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypad_col,
  output logic [3:0] keypad_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    row_drv_q;
  logic [1:0]    acc_n_q;
  logic [3:0]    acc_code_q;

  logic          slot_end;
  logic [1:0]    slot_n;
  logic [1:0]    slot_col;
  logic [2:0]    sum_n;
  logic [1:0]    merged_n;
  logic [3:0]    merged_code;
  logic          frame_done;
  kp_frame_t     frame_type;

  assign slot_end   = (div_cnt_q == DW'(SCAN_DIV - 1));
  assign frame_done = slot_end && (row_q == 2'd3);

  always_comb begin
    div_cnt_d = slot_end ? '0 : div_cnt_q + DW'(1);
    row_d     = slot_end ? row_q + 2'd1 : row_q;
  end

  // Contact count saturates at 2: anything beyond one closed contact is just "multi"
  always_comb begin
    slot_n   = 2'd0;
    slot_col = 2'd0;
    for (int c = 0; c < KP_COLS; c++) begin
      if (!keypad_col[c]) begin
        slot_col = 2'(c);
        slot_n   = (slot_n == 2'd0) ? 2'd1 : 2'd2;
      end
    end
    sum_n       = {1'b0, acc_n_q} + {1'b0, slot_n};
    merged_n    = (sum_n > 3'd1) ? 2'd2 : sum_n[1:0];
    merged_code = (slot_n == 2'd1) ? kp_encode(row_q, slot_col) : acc_code_q;
    case (merged_n)
      2'd0:    frame_type = F_NONE;
      2'd1:    frame_type = F_SINGLE;
      default: frame_type = F_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q  <= '0;
      row_q      <= '0;
      row_drv_q  <= 4'b1110;
      acc_n_q    <= '0;
      acc_code_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      row_q     <= row_d;
      row_drv_q <= ~(4'b0001 << row_d);
      if (slot_end) begin
        if (row_q == 2'd3) begin
          acc_n_q    <= '0;
          acc_code_q <= '0;
        end else begin
          acc_n_q    <= merged_n;
          acc_code_q <= merged_code;
        end
      end
    end
  end

  assign keypad_row = row_drv_q;

  keypad_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .frame_done_i (frame_done),
    .frame_type_i (frame_type),
    .frame_code_i (merged_code),
    .key_code_o   (key_code),
    .key_valid_o  (key_valid),
    .key_strobe_o (key_strobe)
  );

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a switch-matrix keypad model, a frame/streak reference model
// compared every cycle, directed scenarios with literal expectations, then random key activity.
module tb_keypad_scan_debounce;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] keypad_col;
  logic [3:0] keypad_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;
  logic [15:0] pressed = '0;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;

  // reference model state
  int          m_t = 0;
  logic [11:0] m_samp = '0;
  int          m_lastcls = -1;
  int          m_lastcode = 0;
  int          m_streak = 0;
  bit          m_held = 1'b0;
  logic [3:0]  e_row = 4'b1110;
  logic [3:0]  e_code = '0;
  logic        e_valid = 1'b0;
  logic        e_strobe = 1'b0;
  int          slot, fr_n, fr_cls, fr_code;
  logic [15:0] fb;

  logic [3:0] rowtab [4];

  keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .keypad_col (keypad_col),
    .keypad_row (keypad_row),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  // A closed switch ties its column to the row line, so it reads low only while that row is driven
  always_comb begin
    keypad_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !keypad_row[r]) keypad_col[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Frame verdict from the contacts seen at each row's sample; streak of identical verdicts decides
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_t = 0; m_samp = '0; m_lastcls = -1; m_lastcode = 0; m_streak = 0; m_held = 1'b0;
        e_row = 4'b1110; e_code = '0; e_valid = 1'b0; e_strobe = 1'b0;
      end else begin
        slot = (m_t / SD) % 4;
        e_strobe = 1'b0;
        if (m_t % SD == SD - 1 && slot < 3) m_samp[slot*4 +: 4] = pressed[slot*4 +: 4];
        if (m_t % FRAME == FRAME - 1) begin
          fb = {pressed[15:12], m_samp};
          fr_n = $countones(fb);
          fr_cls = (fr_n == 0) ? 0 : ((fr_n == 1) ? 1 : 2);
          fr_code = 0;
          if (fr_cls == 1)
            for (int i = 0; i < 16; i++) if (fb[i]) fr_code = i;
          if (fr_cls == m_lastcls && fr_code == m_lastcode) m_streak++;
          else m_streak = 1;
          m_lastcls = fr_cls;
          m_lastcode = fr_code;
          if (!m_held && fr_cls == 1 && m_streak >= DB) begin
            m_held = 1'b1; e_code = fr_code[3:0]; e_valid = 1'b1; e_strobe = 1'b1;
          end else if (m_held && fr_cls == 0 && m_streak >= DB) begin
            m_held = 1'b0; e_valid = 1'b0;
          end
        end
        m_t++;
        e_row = ~(4'b0001 << ((m_t / SD) % 4));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("keypad_row", keypad_row, e_row);
        check("key_code", key_code, e_code);
        check("key_valid", key_valid, e_valid);
        check("key_strobe", key_strobe, e_strobe);
        if (key_strobe) strobe_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_frame_start();
    for (int i = 0; i < FRAME + 2 && (m_t % FRAME) != 0; i++) tick(1);
    check("frame_align", m_t % FRAME, 0);
  endtask

  task automatic wait_strobe(input int budget, output int lat);
    int s0;
    s0 = strobe_cnt;
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (strobe_cnt != s0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_valid_low(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (!key_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat, s0;
    rowtab[0] = 4'b1110; rowtab[1] = 4'b1101; rowtab[2] = 4'b1011; rowtab[3] = 4'b0111;

    tick(3);
    check("rst_row", keypad_row, 4'b1110);
    check("rst_code", key_code, 4'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_strobe", key_strobe, 1'b0);
    rst = 1'b1;

    // idle scanning
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick(1);
      check("row_scan", keypad_row, rowtab[(m_t / SD) % 4]);
    end
    check("idle_strobes", strobe_cnt, 0);
    check("idle_valid", key_valid, 1'b0);
    check("idle_code", key_code, 4'd0);

    // key 9 held for five frames
    wait_frame_start();
    pressed = 16'h1 << 9;
    wait_strobe(48, lat);
    check("k9_latency", lat, 32);
    check("k9_code", key_code, 4'd9);
    tick(3 * FRAME);
    check("k9_strobes", strobe_cnt, 1);
    check("k9_valid", key_valid, 1'b1);
    wait_frame_start();
    pressed = '0;
    wait_valid_low(48, lat);
    check("k9_release_latency", lat, 32);
    check("k9_code_held", key_code, 4'd9);

    // key 5 for a single frame
    wait_frame_start();
    pressed = 16'h1 << 5;
    tick(FRAME);
    pressed = '0;
    tick(3 * FRAME);
    check("k5_strobes", strobe_cnt, 1);
    check("k5_valid", key_valid, 1'b0);

    // keys 3 and 12 together
    wait_frame_start();
    pressed = (16'h1 << 3) | (16'h1 << 12);
    tick(4 * FRAME);
    pressed = '0;
    tick(3 * FRAME);
    check("multi_strobes", strobe_cnt, 1);
    check("multi_code", key_code, 4'd9);
    check("multi_valid", key_valid, 1'b0);

    // no rollover from 4 to 7
    wait_frame_start();
    pressed = 16'h1 << 4;
    wait_strobe(48, lat);
    check("k4_latency", lat, 32);
    check("k4_code", key_code, 4'd4);
    tick(8);
    pressed = (16'h1 << 4) | (16'h1 << 7);
    tick(FRAME);
    pressed = 16'h1 << 7;
    tick(3 * FRAME);
    check("roll_strobes", strobe_cnt, 2);
    check("roll_code", key_code, 4'd4);
    check("roll_valid", key_valid, 1'b1);
    pressed = '0;
    wait_valid_low(64, lat);
    check("roll_release", key_valid, 1'b0);
    wait_frame_start();
    pressed = 16'h1 << 7;
    wait_strobe(48, lat);
    check("k7_latency", lat, 32);
    check("k7_code", key_code, 4'd7);
    pressed = '0;
    wait_valid_low(64, lat);

    // reset while the candidate has one good frame
    wait_frame_start();
    pressed = 16'h1 << 10;
    tick(FRAME + 3);
    s0 = strobe_cnt;
    rst = 1'b0;
    #1;
    check("mid_rst_row", keypad_row, 4'b1110);
    check("mid_rst_code", key_code, 4'd0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_strobe", key_strobe, 1'b0);
    tick(2);
    rst = 1'b1;
    wait_strobe(64, lat);
    check("post_rst_latency", lat, 32);
    check("post_rst_code", key_code, 4'd10);
    check("post_rst_strobes", strobe_cnt, s0 + 1);
    pressed = '0;
    tick(3 * FRAME);

    // random key activity, durations not aligned to frames
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: pressed = '0;
        1: pressed = 16'h1 << $urandom_range(0, 15);
        2: pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: pressed = 16'h1 << $urandom_range(0, 15);
      endcase
      tick($urandom_range(1, 5 * FRAME));
    end
    pressed = '0;
    tick(4 * FRAME);
    check("final_valid", key_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
